// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential shift-and-add multiplier with valid/ready
// handshakes on the request and result sides. One WIDTH-bit adder is reused
// over WIDTH cycles, which trades latency for a much smaller datapath.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   prod_out,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  // The accumulator's extra top bit is always zero after the right shift,
  // so only its low WIDTH bits are stored; the carry lives in sum[WIDTH].
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;

  // Handshake flags come straight from the registered state.
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Single shared adder: add the multiplicand when the current multiplier bit is set.
  always_comb begin
    sum = {1'b0, acc};
    if (q_reg[0]) begin
      sum = {1'b0, acc} + {1'b0, m_reg};
    end
  end

  // Controller and datapath: accept operands, run WIDTH shift-add steps, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      m_reg      <= '0;
      q_reg      <= '0;
      acc        <= '0;
      count      <= '0;
      prod_out   <= '0;
      done_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            m_reg <= a_in;
            q_reg <= b_in;
            acc   <= '0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= sum[WIDTH:1];
          q_reg <= {sum[0], q_reg[WIDTH-1:1]};
          count <= count + CW'(1);
          if (count == LAST_STEP) begin
            prod_out   <= {sum, q_reg[WIDTH-1:1]};
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: directed checks of the shift-and-add multiplier at
// WIDTH=4 and WIDTH=8, with products computed by the bench from the operands.
module tb_shift_add_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        done_ready;

  logic        start_valid4;
  logic        start_ready4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic [7:0]  prod4;
  logic        done_valid4;
  logic        busy4;

  logic        start_valid8;
  logic        start_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] prod8;
  logic        done_valid8;
  logic        busy8;

  int compared;
  int mismatched;

  shift_add_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid4),
    .start_ready (start_ready4),
    .a_in        (a4),
    .b_in        (b4),
    .prod_out    (prod4),
    .done_valid  (done_valid4),
    .done_ready  (done_ready),
    .busy        (busy4)
  );

  shift_add_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid8),
    .start_ready (start_ready8),
    .a_in        (a8),
    .b_in        (b8),
    .prod_out    (prod8),
    .done_valid  (done_valid8),
    .done_ready  (done_ready),
    .busy        (busy8)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete transaction: wait for ready, accept, scramble operands during
  // RUN, check exact latency and product, optionally hold off done_ready.
  // hold < 0 keeps done_ready high from the start (ignored until DONE).
  task automatic applyStimulus(input bit wide, input logic [7:0] a,
                               input logic [7:0] b, input int hold,
                               input string tag);
    int          lat;
    int          guard;
    logic [15:0] expv;
    lat   = wide ? 8 : 4;
    expv  = wide ? (16'(a) * 16'(b)) : 16'(16'(a[3:0]) * 16'(b[3:0]));
    guard = 0;
    while (!(wide ? start_ready8 : start_ready4) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, " ready"}, 16'(wide ? start_ready8 : start_ready4), 16'd1);
    done_ready = (hold < 0);
    if (wide) begin
      a8 = a; b8 = b; start_valid8 = 1'b1;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; start_valid4 = 1'b1;
    end
    @(negedge clk);
    start_valid4 = 1'b0;
    start_valid8 = 1'b0;
    a4 = ~a4; b4 = ~b4; a8 = ~a8; b8 = ~b8;
    checkOutput({tag, " busy"}, 16'(wide ? busy8 : busy4), 16'd1);
    for (int i = 0; i < lat; i++) begin
      checkOutput({tag, " early"}, 16'(wide ? done_valid8 : done_valid4), 16'd0);
      @(negedge clk);
    end
    checkOutput({tag, " done"}, 16'(wide ? done_valid8 : done_valid4), 16'd1);
    checkOutput({tag, " prod"}, wide ? prod8 : 16'(prod4), expv);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput({tag, " hold dv"}, 16'(wide ? done_valid8 : done_valid4), 16'd1);
      checkOutput({tag, " hold prod"}, wide ? prod8 : 16'(prod4), expv);
      checkOutput({tag, " hold ready"}, 16'(wide ? start_ready8 : start_ready4), 16'd0);
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    checkOutput({tag, " release dv"}, 16'(wide ? done_valid8 : done_valid4), 16'd0);
    checkOutput({tag, " idle"}, 16'(wide ? start_ready8 : start_ready4), 16'd1);
    checkOutput({tag, " kept prod"}, wide ? prod8 : 16'(prod4), expv);
  endtask

  // Directed sequence of steps, then the summary.
  initial begin
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    done_ready   = 1'b0;
    start_valid4 = 1'b0;
    start_valid8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;

    #1;
    checkOutput("reset start_ready", 16'(start_ready4), 16'd1);
    checkOutput("reset busy", 16'(busy4), 16'd0);
    checkOutput("reset done_valid", 16'(done_valid4), 16'd0);
    checkOutput("reset prod", 16'(prod4), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] max operands with done_ready held high");
    applyStimulus(1'b0, 8'd15, 8'd15, -1, "15x15");

    $display("[TB] zero operands");
    applyStimulus(1'b0, 8'd0, 8'd9, 0, "0x9");
    applyStimulus(1'b0, 8'd9, 8'd0, 0, "9x0");

    $display("[TB] backpressure on done_ready");
    applyStimulus(1'b0, 8'd13, 8'd11, 5, "13x11");

    $display("[TB] request held during RUN with toggling operands");
    a4 = 4'd6; b4 = 4'd7; start_valid4 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkOutput("toggle ready low", 16'(start_ready4), 16'd0);
      a4 = (i % 2 == 0) ? 4'd12 : 4'd5;
      b4 = (i % 2 == 0) ? 4'd10 : 4'd14;
      @(negedge clk);
    end
    a4 = 4'd3; b4 = 4'd3;
    checkOutput("toggle done", 16'(done_valid4), 16'd1);
    checkOutput("toggle prod 6x7", 16'(prod4), 16'h002A);
    checkOutput("toggle ready in done", 16'(start_ready4), 16'd0);
    done_ready = 1'b1;
    @(negedge clk);
    checkOutput("toggle back idle", 16'(start_ready4), 16'd1);
    checkOutput("toggle dv low", 16'(done_valid4), 16'd0);
    done_ready = 1'b0;
    @(negedge clk);
    start_valid4 = 1'b0;
    checkOutput("second accepted", 16'(busy4), 16'd1);
    for (int i = 0; i < 4; i++) @(negedge clk);
    checkOutput("second done", 16'(done_valid4), 16'd1);
    checkOutput("second prod 3x3", 16'(prod4), 16'h0009);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;

    $display("[TB] reset in the middle of RUN");
    a4 = 4'd12; b4 = 4'd12; start_valid4 = 1'b1;
    @(negedge clk);
    start_valid4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset start_ready", 16'(start_ready4), 16'd1);
    checkOutput("midreset busy", 16'(busy4), 16'd0);
    checkOutput("midreset done_valid", 16'(done_valid4), 16'd0);
    checkOutput("midreset prod", 16'(prod4), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("post reset no dv", 16'(done_valid4), 16'd0);
      checkOutput("post reset idle", 16'(start_ready4), 16'd1);
    end

    $display("[TB] exhaustive WIDTH=4 sweep");
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(1'b0, 8'(a), 8'(b), int'($urandom_range(0, 2)), "sweep4");
      end
    end

    $display("[TB] WIDTH=8 subset");
    applyStimulus(1'b1, 8'd255, 8'd255, 1, "255x255");
    applyStimulus(1'b1, 8'h80, 8'd2, 0, "128x2");
    applyStimulus(1'b1, 8'd0, 8'd200, 0, "0x200");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2)), "rand8");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
